// File: rtl/brpred_mon_pkg.sv
// Shared types and default widths for the branch-predictor performance monitor.
package brpred_mon_pkg;

    localparam int unsigned DEF_NUM_PHASES = 3;
    localparam int unsigned DEF_ADDR_W     = 30;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_ERR_W      = 8;
    localparam int unsigned DEF_TIMEOUT    = 32'h0000_FFFF;
    localparam int unsigned PHASE_W        = 4;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DONE = 2'd1,
        TOUT = 2'd2
    } mon_state_t;

    typedef logic [PHASE_W-1:0] phase_t;

endpackage

// File: rtl/brpred_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over count.
module brpred_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    // Count on enable, hold once every bit is set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/brpred_perf_monitor.sv
// Branch-predictor test monitor: tracks phase markers written on the data
// port, counts errors and performance events, ends the run on pass/timeout.
// Optional feature macro: BRPRED_PHASE_ERR_EN builds per-phase error counters.
module brpred_perf_monitor
    import brpred_mon_pkg::*;
#(
    parameter int unsigned        NUM_PHASES     = DEF_NUM_PHASES,
    parameter int unsigned        ADDR_W         = DEF_ADDR_W,
    parameter int unsigned        DATA_W         = DEF_DATA_W,
    parameter int unsigned        CNT_W          = DEF_CNT_W,
    parameter int unsigned        ERR_W          = DEF_ERR_W,
    parameter logic [ADDR_W-1:0]  CHECK_ADDR     = '0,
    parameter logic [DATA_W-1:0]  PASS_DATA      = '0,
    parameter int unsigned        TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           data,
    input  logic                        wen,
    input  logic [ADDR_W-1:0]           I_addr,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        br_type,
    output logic [3:0]                  phase,
    output logic [ERR_W-1:0]            error_num,
    output logic [CNT_W-1:0]            duration,
    output logic [CNT_W-1:0]            stall_cycles,
    output logic [CNT_W-1:0]            flush_count,
    output logic [CNT_W-1:0]            inst_count,
    output logic [CNT_W-1:0]            branch_count,
    output logic [NUM_PHASES*ERR_W-1:0] phase_err,
    output logic                        finish,
    output logic                        timeout
);

    localparam phase_t            LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
    localparam logic [CNT_W-1:0]  TOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit                TOUT_EN    = (TIMEOUT_CYCLES != 0);

    mon_state_t          state;
    mon_state_t          state_next;
    phase_t              phase_next;
    logic                wen_q;
    logic [ADDR_W-1:0]   prev_i_addr;

    logic                in_run;
    logic                accept;
    logic                is_pass;
    logic                err_hit;
    logic                new_fetch;
    logic                tout_hit;

    // Event qualification: first cycle of a wen burst, new fetch address, timeout point
    assign in_run    = (state == RUN);
    assign accept    = wen & ~wen_q & (addr == CHECK_ADDR) & in_run;
    assign is_pass   = (data == PASS_DATA);
    assign err_hit   = accept & ~is_pass;
    assign new_fetch = ~stall & ~flush & (I_addr != prev_i_addr);
    assign tout_hit  = TOUT_EN & in_run & (duration == TOUT_LAST);

    // State, phase and end-of-run flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            phase   <= '0;
            finish  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_next;
            phase   <= phase_next;
            finish  <= (state_next != RUN);
            timeout <= (state_next == TOUT);
        end
    end

    // Next state: final pass marker takes precedence over a coincident timeout
    always_comb begin
        state_next = state;
        phase_next = phase;
        case (state)
            RUN: begin
                if (accept && is_pass) begin
                    phase_next = phase + PHASE_W'(1);
                    if (phase == LAST_PHASE) begin
                        state_next = DONE;
                    end
                end
                if ((state_next == RUN) && tout_hit) begin
                    state_next = TOUT;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    // Previous write enable for burst edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q <= 1'b0;
        end else begin
            wen_q <= wen;
        end
    end

    // Last fetch address seen outside stalls; all-ones so the first fetch counts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_i_addr <= '1;
        end else if (!stall) begin
            prev_i_addr <= I_addr;
        end
    end

    brpred_sat_counter #(.W(CNT_W)) u_duration (
        .clk(clk), .rst(rst), .en(in_run), .clr(1'b0), .q(duration)
    );

    brpred_sat_counter #(.W(CNT_W)) u_stall (
        .clk(clk), .rst(rst), .en(in_run & stall), .clr(1'b0), .q(stall_cycles)
    );

    brpred_sat_counter #(.W(CNT_W)) u_flush (
        .clk(clk), .rst(rst), .en(in_run & flush), .clr(1'b0), .q(flush_count)
    );

    brpred_sat_counter #(.W(CNT_W)) u_inst (
        .clk(clk), .rst(rst), .en(in_run & new_fetch), .clr(1'b0), .q(inst_count)
    );

    brpred_sat_counter #(.W(CNT_W)) u_branch (
        .clk(clk), .rst(rst), .en(in_run & new_fetch & br_type), .clr(1'b0), .q(branch_count)
    );

    brpred_sat_counter #(.W(ERR_W)) u_error (
        .clk(clk), .rst(rst), .en(err_hit), .clr(1'b0), .q(error_num)
    );

`ifdef BRPRED_PHASE_ERR_EN
    // One error counter per phase, selected by the current phase index
    for (genvar p = 0; p < int'(NUM_PHASES); p++) begin : g_phase_err
        brpred_sat_counter #(.W(ERR_W)) u_phase_err (
            .clk(clk),
            .rst(rst),
            .en(err_hit & (phase == PHASE_W'(p))),
            .clr(1'b0),
            .q(phase_err[p*ERR_W +: ERR_W])
        );
    end
`else
    assign phase_err = '0;
`endif

endmodule

// File: tb/tb_brpred_perf_monitor.sv
// Self-checking bench for brpred_perf_monitor: two instances (default timeout
// and a 20-cycle timeout) checked every cycle against a behavioural model.
module tb_brpred_perf_monitor;

    localparam int NP   = 3;
    localparam int CMAX = 65535;
    localparam int EMAX = 255;

    logic        clk;
    logic        rst;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic [29:0] i_addr;
    logic        stall;
    logic        flush;
    logic        br_type;

    logic [3:0]  phase_a,  phase_t;
    logic [7:0]  err_a,    err_t;
    logic [15:0] dur_a,    dur_t;
    logic [15:0] stl_a,    stl_t;
    logic [15:0] fl_a,     fl_t;
    logic [15:0] inst_a,   inst_t;
    logic [15:0] br_a,     br_t;
    logic [23:0] perr_a,   perr_t;
    logic        fin_a,    fin_t;
    logic        to_a,     to_t;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    brpred_perf_monitor #(.TIMEOUT_CYCLES(32'hFFFF)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
        .I_addr(i_addr), .stall(stall), .flush(flush), .br_type(br_type),
        .phase(phase_a), .error_num(err_a), .duration(dur_a),
        .stall_cycles(stl_a), .flush_count(fl_a), .inst_count(inst_a),
        .branch_count(br_a), .phase_err(perr_a), .finish(fin_a), .timeout(to_a)
    );

    brpred_perf_monitor #(.TIMEOUT_CYCLES(20)) dut_to (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
        .I_addr(i_addr), .stall(stall), .flush(flush), .br_type(br_type),
        .phase(phase_t), .error_num(err_t), .duration(dur_t),
        .stall_cycles(stl_t), .flush_count(fl_t), .inst_count(inst_t),
        .branch_count(br_t), .phase_err(perr_t), .finish(fin_t), .timeout(to_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int          st;       // 0 running, 1 passed, 2 timed out
        int          phase;
        int          err;
        int          dur, stl, fl, inst, br;
        int          perr [NP];
        bit          wq;
        logic [29:0] prev;
    } model_t;

    model_t m_a, m_t;

    function automatic int sat(input int x, input int maxv);
        return (x >= maxv) ? maxv : x + 1;
    endfunction

    function automatic model_t mreset();
        model_t m;
        m.st = 0; m.phase = 0; m.err = 0;
        m.dur = 0; m.stl = 0; m.fl = 0; m.inst = 0; m.br = 0;
        for (int p = 0; p < NP; p++) m.perr[p] = 0;
        m.wq = 1'b0;
        m.prev = '1;
        return m;
    endfunction

    function automatic model_t mstep(input model_t m, input int tmo);
        model_t n;
        bit     running;
        bit     acc;
        bit     hit;
        n       = m;
        running = (m.st == 0);
        acc     = wen && !m.wq && (addr == 30'd0) && running;
        hit     = running && (tmo != 0) && (m.dur == tmo - 1);
        if (running) begin
            n.dur = sat(m.dur, CMAX);
            if (stall) n.stl = sat(m.stl, CMAX);
            if (flush) n.fl  = sat(m.fl, CMAX);
            if (!stall && !flush && (i_addr != m.prev)) begin
                n.inst = sat(m.inst, CMAX);
                if (br_type) n.br = sat(m.br, CMAX);
            end
        end
        if (acc) begin
            if (data == 32'd0) begin
                n.phase = m.phase + 1;
                if (n.phase == NP) n.st = 1;
            end else begin
                n.err = sat(m.err, EMAX);
                n.perr[m.phase] = sat(m.perr[m.phase], EMAX);
            end
        end
        if ((n.st == 0) && hit) n.st = 2;
        if (!stall) n.prev = i_addr;
        n.wq = wen;
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_a <= mreset();
            m_t <= mreset();
        end else begin
            m_a <= mstep(m_a, 65535);
            m_t <= mstep(m_t, 20);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] perr_vec(input model_t m);
        logic [23:0] v;
        v = '0;
`ifdef BRPRED_PHASE_ERR_EN
        for (int p = 0; p < NP; p++) v[p*8 +: 8] = 8'(m.perr[p]);
`endif
        return v;
    endfunction

    task automatic check_inst(input string tag, input model_t m,
                              input logic [3:0] ph, input logic [7:0] e,
                              input logic [15:0] d, input logic [15:0] s,
                              input logic [15:0] f, input logic [15:0] i,
                              input logic [15:0] b, input logic [23:0] pe,
                              input logic fin, input logic to);
        chk({tag, "_phase"},     ph,  m.phase);
        chk({tag, "_error_num"}, e,   m.err);
        chk({tag, "_duration"},  d,   m.dur);
        chk({tag, "_stall"},     s,   m.stl);
        chk({tag, "_flush"},     f,   m.fl);
        chk({tag, "_inst"},      i,   m.inst);
        chk({tag, "_branch"},    b,   m.br);
        chk({tag, "_phase_err"}, pe,  perr_vec(m));
        chk({tag, "_finish"},    fin, (m.st != 0) ? 1 : 0);
        chk({tag, "_timeout"},   to,  (m.st == 2) ? 1 : 0);
    endtask

    // Every cycle, away from the active edge, compare both instances to the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check_inst("a", m_a, phase_a, err_a, dur_a, stl_a, fl_a, inst_a,
                       br_a, perr_a, fin_a, to_a);
            check_inst("t", m_t, phase_t, err_t, dur_t, stl_t, fl_t, inst_t,
                       br_t, perr_t, fin_t, to_t);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic marker(input logic [31:0] d);
        addr = 30'd0;
        data = d;
        wen  = 1'b1;
        tick();
        wen  = 1'b0;
        tick();
    endtask

    // Fetch vector: {I_addr, stall, flush, type}
    logic [29:0] fv_addr [14] = '{30'd1, 30'd2, 30'd3, 30'd3, 30'd3, 30'd4, 30'd4,
                                  30'd5, 30'd6, 30'd7, 30'd7, 30'd8, 30'd9, 30'd10};
    logic        fv_stl  [14] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic        fv_fl   [14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    logic        fv_br   [14] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

    initial begin
        logic [23:0] pe_exp;
        rst = 1'b1; addr = '0; data = '0; wen = 1'b0;
        i_addr = 30'd1; stall = 1'b0; flush = 1'b0; br_type = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        cmp_en = 1;

        // Reset values
        chk("rst_phase",    phase_a, 0);
        chk("rst_finish",   fin_a,   0);
        chk("rst_duration", dur_a,   0);
        chk("rst_inst",     inst_a,  0);
        tick();
        tick();
        rst = 1'b1;

        // Fetch / stall / flush counting and 20-cycle timeout
        for (int k = 0; k < 14; k++) begin
            i_addr  = fv_addr[k];
            stall   = fv_stl[k];
            flush   = fv_fl[k];
            br_type = fv_br[k];
            tick();
        end
        stall = 1'b0; flush = 1'b0; br_type = 1'b0;
        repeat (10) tick();
        chk("fetch_inst",   inst_a, 10);
        chk("fetch_branch", br_a,   2);
        chk("fetch_stall",  stl_a,  3);
        chk("fetch_flush",  fl_a,   1);
        chk("run_duration", dur_a,  24);
        chk("run_finish",   fin_a,  0);
        chk("tout_duration", dur_t, 20);
        chk("tout_finish",   fin_t, 1);
        chk("tout_timeout",  to_t,  1);
        repeat (5) tick();
        chk("tout_frozen",   dur_t, 20);

        // Three clean pass markers
        do_reset();
        marker(32'd0);
        chk("pass_phase1", phase_a, 1);
        marker(32'd0);
        addr = 30'd0; data = 32'd0; wen = 1'b1;
        tick();
        chk("pass_finish_next", fin_a, 1);
        wen = 1'b0;
        tick();
        chk("pass_phase3",  phase_a, 3);
        chk("pass_errors",  err_a,   0);
        chk("pass_timeout", to_a,    0);
        marker(32'd5);
        chk("done_no_err",  err_a,   0);
        chk("done_phase",   phase_a, 3);

        // Wrong marker in phase 1
        do_reset();
        marker(32'd0);
        marker(32'd5);
        marker(32'd0);
        marker(32'd0);
        chk("err_count", err_a,   1);
        chk("err_phase", phase_a, 3);
        pe_exp = 24'h0;
`ifdef BRPRED_PHASE_ERR_EN
        pe_exp = 24'h00_01_00;
`endif
        chk("err_phase_err", perr_a, pe_exp);

        // Long wen burst counts once, other addresses ignored
        do_reset();
        addr = 30'd0; data = 32'd0; wen = 1'b1;
        repeat (4) tick();
        wen = 1'b0;
        tick();
        chk("burst_phase", phase_a, 1);
        addr = 30'd7; data = 32'd0; wen = 1'b1;
        tick();
        wen = 1'b0;
        tick();
        chk("other_addr_phase", phase_a, 1);
        marker(32'd0);
        chk("mid_phase2", phase_a, 2);

        // Asynchronous reset mid-run
        rst = 1'b0;
        #1;
        chk("arst_phase",    phase_a, 0);
        chk("arst_duration", dur_a,   0);
        chk("arst_inst",     inst_a,  0);
        chk("arst_finish",   fin_a,   0);
        chk("arst_errors",   err_a,   0);
        tick();
        rst = 1'b1;
        marker(32'd0);
        marker(32'd0);
        marker(32'd0);
        chk("rerun_phase",  phase_a, 3);
        chk("rerun_finish", fin_a,   1);
        tick();

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/brpred_perf_monitor.md
# brpred_perf_monitor

Synthesizable, parametrised successor of the branch-predictor test monitor. It sits beside the CPU core in the BrPred test harness and watches the data-side write port for per-phase completion markers. It counts errors, and measures cycles, memory stalls, flushes, instructions and branches with real saturating counters. It ends the run on pass or on timeout.

## Interface
- NUM_PHASES, 3, number of completion markers expected before finish (1..15)
- ADDR_W, 30, word-address width of `addr` / `I_addr`
- DATA_W, 32, write-data width
- CNT_W, 16, width of every performance counter
- ERR_W, 8, error-counter width
- CHECK_ADDR, 0, word address monitored for markers
- PASS_DATA, 0, marker value meaning "phase passed"
- TIMEOUT_CYCLES, 16'hFFFF, run cycles before forced end; 0 disables timeout

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- addr  in  ADDR_W  data-side word address
- data  in  DATA_W  data-side write data
- wen  in  1  data-side write enable (may stay high across D-cache stall cycles)
- I_addr  in  ADDR_W  instruction fetch word address
- stall  in  1  memory stall indicator
- flush  in  1  pipeline flush (branch mispredict)
- type  in  1  fetched instruction is a branch
- phase  out  4  index of current phase
- error_num  out  ERR_W  wrong-marker count, saturating
- duration  out  CNT_W  cycles spent in RUN
- stall_cycles  out  CNT_W  RUN cycles with stall=1
- flush_count  out  CNT_W  RUN cycles with flush=1
- inst_count  out  CNT_W  retired-fetch count
- branch_count  out  CNT_W  branch-fetch count
- phase_err  out  NUM_PHASES*ERR_W  per-phase error counts, phase 0 in LSBs
- finish  out  1  run ended (pass or timeout)
- timeout  out  1  run ended by timeout

## Operation
- States: RUN, DONE, TOUT. Reset enters RUN with phase=0.
- Write acceptance: a write is accepted only on the first cycle of a wen-high burst.
  - A 1-bit `wen_q` register tracks previous wen.
  - accept = wen & ~wen_q & (addr == CHECK_ADDR) & (state == RUN).
- On accept:
  - If data == PASS_DATA: phase += 1. If that was phase NUM_PHASES-1, go to DONE; phase holds at NUM_PHASES.
  - Otherwise: error_num += 1, saturating at all-ones.
- Counters advance only in RUN, saturate at all-ones, and freeze in DONE/TOUT:
  - duration: +1 every cycle.
  - stall_cycles: +1 when stall=1.
  - flush_count: +1 when flush=1.
  - New fetch = ~stall & ~flush & (I_addr != prev_I_addr). On a new fetch, inst_count +1, and branch_count +1 if type=1.
  - prev_I_addr updates on every ~stall cycle. Its reset value is all-ones.
- Timeout:
  - Applies when TIMEOUT_CYCLES != 0.
  - In RUN with duration == TIMEOUT_CYCLES-1: go to TOUT.
  - If an accepted final pass marker coincides with this condition, DONE wins.
- finish = (state != RUN). timeout = (state == TOUT).
- DONE and TOUT are terminal until reset.

## Timing
- Registered outputs: all counters and phase update on the clock edge after the qualifying input cycle.
- finish and timeout are decoded from the state register, so they are high the cycle after the final marker.
- Reset (async assert, any time, including mid-run) forces every output to 0, phase=0, wen_q=0, state=RUN.
- Reset release is synchronous to clk.
- A wen held high for N cycles counts once; a new marker needs wen low for at least 1 cycle.

## Configuration
- BRPRED_PHASE_ERR_EN defined:
  - Per-phase error counters are built.
  - A wrong marker in phase p increments phase_err slice p, saturating.
- Not defined: phase_err is tied to 0, no registers are built, and error_num is unaffected.

## Structure
- Package brpred_mon_pkg holds:
  - state enum (RUN, DONE, TOUT)
  - phase-index typedef
  - default width constants
- Sub-module brpred_sat_counter holds one saturating counter.
  - Parameter W; inputs clk, rst, en, clr; output q.
  - Instantiated for every performance counter, error_num and each phase_err slice.

## Test plan
- Three accepted writes of 0 to addr 0, separated by wen low -> phase 0→1→2→3, finish=1 next cycle, error_num=0, timeout=0.
- Write data=5 to addr 0 in phase 1, then pass -> error_num=1. With BRPRED_PHASE_ERR_EN, phase_err slice 1 = 1 and the others are 0.
- wen held high 4 cycles with addr 0, data 0 -> phase advances by exactly 1.
- TIMEOUT_CYCLES=20 with no markers -> TOUT after 20 RUN cycles, duration=20 and frozen, finish=timeout=1.
- 10 fetches at distinct I_addr (2 with type=1), 3 stall cycles, 1 flush cycle -> inst_count=10, branch_count=2, stall_cycles=3, flush_count=1.
- Assert rst mid-phase 2 -> all outputs 0 immediately, phase=0; the next three pass markers complete normally.
